// File: rtl/updata_seq_ctrl.sv
// Two-way round-robin arbiter and sequencer for the updata loader.
// Drives the 3-beat in_RDY8 frame, waits for completion, returns result.
module updata_seq_ctrl #(
  parameter int MAX_ST  = 15,
  parameter int TIMEOUT = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [7:0] cnt0,
  input  logic [7:0] loc0,
  input  logic [7:0] cnt1,
  input  logic [7:0] loc1,
  output logic [1:0] gnt,
  output logic [1:0] done,
  output logic       err,
  output logic [7:0] result,
  output logic       busy,
  output logic       upd_in_RDY8,
  output logic [7:0] upd_DATA_in8,
  input  logic       upd_state_cmp8,
  input  logic       upd_out_RDY8,
  input  logic [7:0] upd_DATA_out8
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_CNT, S_LOC,
    S_CLR, S_WAIT, S_DONE, S_ERR
  } state_t;

  state_t        state, nxt;
  logic          last;
  logic          win1;
  logic [7:0]    sel_cnt, sel_loc;
  logic          valid;
  logic          tmo;
  logic [7:0]    cnt_q, loc_q;
  logic [TW-1:0] tcnt;

  // round-robin pick and request validation on the live inputs
  always_comb begin
    win1    = req[1] && (!req[0] || !last);
    sel_cnt = win1 ? cnt1 : cnt0;
    sel_loc = win1 ? loc1 : loc0;
    valid   = (sel_cnt != 8'd0)
           && (sel_cnt <= 8'(MAX_ST))
           && (sel_loc[3:0] != 4'd0)
           && ({4'd0, sel_loc[3:0]} <= sel_cnt)
           && (sel_loc[7:4] != 4'd0);
    tmo     = (tcnt == TLAST);
  end

  // next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (|req) nxt = valid ? S_SYNC : S_ERR;
      S_SYNC: nxt = S_CNT;
      S_CNT:  nxt = S_LOC;
      S_LOC:  nxt = S_CLR;
      S_CLR:  nxt = S_WAIT;
      S_WAIT: if (upd_state_cmp8 || tmo) nxt = S_DONE;
      S_DONE: nxt = S_IDLE;
      S_ERR:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Moore decode of the updata drive and done pulse
  always_comb begin
    upd_in_RDY8  = 1'b0;
    upd_DATA_in8 = 8'h00;
    busy         = (state != S_IDLE);
    done         = 2'b00;
    unique case (1'b1)
      (state == S_SYNC): upd_in_RDY8 = 1'b1;
      (state == S_CNT): begin
        upd_in_RDY8  = 1'b1;
        upd_DATA_in8 = cnt_q;
      end
      (state == S_LOC): begin
        upd_in_RDY8  = 1'b1;
        upd_DATA_in8 = loc_q;
      end
      (state == S_DONE),
      (state == S_ERR): done = gnt;
      default: ;
    endcase
  end

  // state register, grant, capture and timeout datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      gnt    <= 2'b00;
      err    <= 1'b0;
      result <= 8'h00;
      last   <= 1'b1;
      tcnt   <= '0;
      cnt_q  <= 8'h00;
      loc_q  <= 8'h00;
    end else begin
      state <= nxt;
      unique case (state)
        S_IDLE: if (|req) begin
          gnt    <= win1 ? 2'b10 : 2'b01;
          last   <= win1;
          cnt_q  <= sel_cnt;
          loc_q  <= sel_loc;
          err    <= !valid;
          result <= 8'h00;
          tcnt   <= '0;
        end
        S_WAIT: begin
          tcnt <= tcnt + TW'(1);
          if (upd_state_cmp8) begin
            err <= 1'b0;
            if (upd_out_RDY8) result <= upd_DATA_out8;
          end else if (tmo) begin
            err    <= 1'b1;
            result <= 8'hFF;
          end else if (upd_out_RDY8) begin
            result <= upd_DATA_out8;
          end
        end
        S_DONE, S_ERR: gnt <= 2'b00;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_updata_seq_ctrl.sv
// Self-checking bench for updata_seq_ctrl.
// Reference expectations computed from request rules; updata modelled.
module tb_updata_seq_ctrl;

  localparam int MAX_ST  = 15;
  localparam int TIMEOUT = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req;
  logic [7:0] cnt0, loc0, cnt1, loc1;
  logic [1:0] gnt, done;
  logic       err, busy;
  logic [7:0] result;
  logic       upd_in_RDY8;
  logic [7:0] upd_DATA_in8;
  logic       upd_state_cmp8;
  logic       upd_out_RDY8;
  logic [7:0] upd_DATA_out8;

  int compared = 0;
  int mism     = 0;
  int last_srv = 1;

  int         resp_n = 0;
  int         resp_k = 0;
  logic [7:0] resp_d = 8'h00;
  int         wc     = 0;
  int         run    = 0;

  updata_seq_ctrl #(.MAX_ST(MAX_ST), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req),
    .cnt0(cnt0), .loc0(loc0), .cnt1(cnt1), .loc1(loc1),
    .gnt(gnt), .done(done), .err(err), .result(result),
    .busy(busy), .upd_in_RDY8(upd_in_RDY8),
    .upd_DATA_in8(upd_DATA_in8),
    .upd_state_cmp8(upd_state_cmp8),
    .upd_out_RDY8(upd_out_RDY8),
    .upd_DATA_out8(upd_DATA_out8)
  );

  always #5 clk = ~clk;

  // updata peripheral model: after a 3-beat frame, count WAIT cycles
  always @(negedge clk) begin
    upd_state_cmp8 = 1'b0;
    upd_out_RDY8   = 1'b0;
    upd_DATA_out8  = 8'h00;
    if (wc > 0) begin
      if (resp_k == wc) begin
        upd_out_RDY8  = 1'b1;
        upd_DATA_out8 = resp_d;
      end
      if (resp_n == wc) begin
        upd_state_cmp8 = 1'b1;
        wc = 0;
      end else if (wc > 40) begin
        wc = 0;
      end else begin
        wc = wc + 1;
      end
    end
    if (upd_in_RDY8) run = run + 1;
    else begin
      if (run == 3) wc = 1;
      run = 0;
    end
  end

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) return (last_srv == 1) ? 0 : 1;
    return r[1] ? 1 : 0;
  endfunction

  task automatic check_service(
    input int g, input logic [7:0] c, input logic [7:0] l,
    input int n, input int k, input logic [7:0] d, input bit rearm);
    bit v, got, seen;
    int neff, lat, cyc, bad;
    logic [7:0] er, ed;
    logic [1:0] eg;
    bit ee, erdy;
    v = (c >= 1) && (c <= MAX_ST) && (l[3:0] >= 1)
     && (l[3:0] <= c) && (l[7:4] != 0);
    neff = (n >= 1 && n <= TIMEOUT) ? n : TIMEOUT;
    lat  = v ? 5 + neff : 1;
    ee   = !v || (n == 0);
    er   = !v ? 8'h00 : ((n == 0) ? 8'hFF : d);
    eg   = (g == 0) ? 2'b01 : 2'b10;
    if (g == 0) begin cnt0 = c; loc0 = l; end
    else begin cnt1 = c; loc1 = l; end
    resp_n = n; resp_k = k; resp_d = d;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) got = 1;
    end
    compared++;
    if (!got) begin
      mism++;
      $display("FAIL grant_wait g=%0d got gnt=%b want %b", g, gnt, eg);
      return;
    end
    if (g == 0) begin cnt0 = 8'($urandom); loc0 = 8'($urandom); end
    else begin cnt1 = 8'($urandom); loc1 = 8'($urandom); end
    cyc = 1; bad = 0; seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      erdy = v && (cyc <= 3);
      ed = (!v || cyc == 1 || cyc > 3) ? 8'h00 : (cyc == 2 ? c : l);
      if (bad == 0 && (gnt !== eg || busy !== 1'b1
          || upd_in_RDY8 !== erdy || upd_DATA_in8 !== ed))
        bad = cyc;
      if (done != 2'b00) seen = 1;
      else begin
        cyc++;
        @(negedge clk);
      end
    end
    compared++;
    if (bad != 0) begin
      mism++;
      $display("FAIL frame_gnt g=%0d cycle %0d gnt=%b rdy=%b data=%h",
               g, bad, gnt, upd_in_RDY8, upd_DATA_in8);
    end
    compared++;
    if (!seen || cyc != lat) begin
      mism++;
      $display("FAIL latency g=%0d got %0d want %0d seen=%0d",
               g, cyc, lat, seen);
    end
    compared++;
    if (done !== eg) begin
      mism++;
      $display("FAIL done_vec got %b want %b", done, eg);
    end
    compared++;
    if (err !== ee || result !== er) begin
      mism++;
      $display("FAIL err_result got %b/%h want %b/%h", err, result, ee, er);
    end
    req[g] = 1'b0;
    @(negedge clk);
    compared++;
    if (gnt !== 2'b00 || busy !== 1'b0 || done !== 2'b00) begin
      mism++;
      $display("FAIL post_idle got gnt=%b busy=%b done=%b want 00/0/00",
               gnt, busy, done);
    end
    last_srv = g;
    if (rearm) req[g] = 1'b1;
  endtask

  task automatic do_reset();
    req = 2'b00;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_srv = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 2'($urandom);
    repeat (3) @(negedge clk);
    compared++;
    if (gnt !== 2'b00 || done !== 2'b00 || err !== 1'b0
        || result !== 8'h00 || busy !== 1'b0
        || upd_in_RDY8 !== 1'b0 || upd_DATA_in8 !== 8'h00) begin
      mism++;
      $display("FAIL reset_state gnt=%b done=%b err=%b res=%h busy=%b rdy=%b want zeros",
               gnt, done, err, result, busy, upd_in_RDY8);
    end
    do_reset();
  endtask

  task automatic test_single();
    req = 2'b01;
    check_service(0, 8'h08, 8'h22, 3, 3, 8'h5A, 0);
  endtask

  task automatic test_contention();
    do_reset();
    req = 2'b11;
    check_service(pick(req), 8'h05, 8'h13, 1, 1, 8'hA1, 1);
    check_service(pick(req), 8'h07, 8'h27, 1, 1, 8'hB2, 1);
    check_service(pick(req), 8'h03, 8'h31, 1, 1, 8'hC3, 1);
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_invalid();
    req = 2'b01;
    check_service(0, 8'h00, 8'h22, 2, 1, 8'h11, 0);
    req = 2'b01;
    check_service(0, 8'h08, 8'h29, 2, 1, 8'h11, 0);
    req = 2'b01;
    check_service(0, 8'h08, 8'h02, 2, 1, 8'h11, 0);
  endtask

  task automatic test_timeout();
    req = 2'b01;
    check_service(0, 8'h04, 8'h14, 0, 0, 8'h00, 0);
    req = 2'b01;
    check_service(0, 8'h04, 8'h14, 2, 2, 8'h66, 0);
  endtask

  task automatic test_reset_midframe();
    bit got;
    cnt0 = 8'h08; loc0 = 8'h22;
    resp_n = 2; resp_k = 1; resp_d = 8'h3C;
    req = 2'b01;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (gnt != 2'b00) got = 1;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if (!got || gnt !== 2'b00 || busy !== 1'b0 || done !== 2'b00
        || upd_in_RDY8 !== 1'b0 || upd_DATA_in8 !== 8'h00) begin
      mism++;
      $display("FAIL reset_mid got=%0d gnt=%b busy=%b done=%b rdy=%b data=%h",
               got, gnt, busy, done, upd_in_RDY8, upd_DATA_in8);
    end
    rst = 1'b0;
    last_srv = 1;
    check_service(0, 8'h08, 8'h22, 2, 1, 8'h3C, 0);
  endtask

  task automatic test_boundary();
    req = 2'b10;
    check_service(1, 8'h0F, 8'h1F, 2, 2, 8'h77, 0);
    req = 2'b10;
    check_service(1, 8'h10, 8'h1F, 2, 2, 8'h77, 0);
  endtask

  task automatic test_random();
    logic [1:0] r;
    logic [7:0] c, l;
    int n, k, g;
    for (int t = 0; t < 25; t++) begin
      r = 2'($urandom_range(1, 3));
      c = 8'($urandom_range(0, 17));
      l = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
      if ($urandom_range(0, 3) != 0 && c >= 1 && c <= 15)
        l[3:0] = 4'($urandom_range(1, int'(c)));
      n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
      k = (n == 0) ? 0 : $urandom_range(1, n);
      cnt0 = 8'($urandom); loc0 = 8'($urandom);
      cnt1 = 8'($urandom); loc1 = 8'($urandom);
      req = r;
      g = pick(r);
      check_service(g, c, l, n, k, 8'($urandom), 0);
      req = 2'b00;
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 2'b00;
    cnt0 = 8'h00; loc0 = 8'h00;
    cnt1 = 8'h00; loc1 = 8'h00;
    test_reset();
    test_single();
    test_contention();
    test_invalid();
    test_timeout();
    test_reset_midframe();
    test_boundary();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mism);
    $finish;
  end

endmodule
